// File: rtl/aes_round_ctrl.sv
// AES encryption round sequencer around an external sub_bytes datapath and key store.
// Optional debug taps (o_dbg_state, o_dbg_round) are enabled by defining AES_CTRL_DBG_EN.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int SB_LATENCY = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_data_in,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_data_out,
  output logic [3:0]   o_rk_idx,
  input  logic [127:0] i_round_key,
  output logic [127:0] o_sb_data,
  input  logic [127:0] i_sb_data
`ifdef AES_CTRL_DBG_EN
  ,
  output logic [1:0]   o_dbg_state,
  output logic [3:0]   o_dbg_round
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [1:0] WAIT_LAST  = 2'(SB_LATENCY - 1);

  state_t       state;
  logic [127:0] state_reg;
  logic [3:0]   round_cnt;
  logic [1:0]   wait_cnt;
  logic         valid_q;
  logic         ready_q;
  logic [127:0] sr_data;
  logic [127:0] mc_data;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of the output takes column (c + r) mod 4 of the input.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c      -: 8];
      a1 = s[127 - 32*c - 8  -: 8];
      a2 = s[127 - 32*c - 16 -: 8];
      a3 = s[127 - 32*c - 24 -: 8];
      r[127 - 32*c      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[127 - 32*c - 8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[127 - 32*c - 24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  assign sr_data = shift_rows(i_sb_data);
  assign mc_data = mix_columns(sr_data);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      state_reg <= '0;
      round_cnt <= '0;
      wait_cnt  <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid && ready_q) begin
            state_reg <= i_data_in ^ i_round_key;
            round_cnt <= 4'd1;
            wait_cnt  <= '0;
            ready_q   <= 1'b0;
            state     <= SUB;
          end
        end
        // Hold the state steady while the s_box pipeline drains.
        SUB: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            state    <= MIX;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        MIX: begin
          if (round_cnt == LAST_ROUND) begin
            state_reg <= sr_data ^ i_round_key;
            valid_q   <= 1'b1;
            state     <= DONE;
          end else begin
            state_reg <= mc_data ^ i_round_key;
            round_cnt <= round_cnt + 4'd1;
            state     <= SUB;
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
            round_cnt <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The round counter doubles as the key-store index: 0 in IDLE, NUM_ROUNDS in DONE.
  assign o_rk_idx   = round_cnt;
  assign o_ready    = ready_q & ~i_rst;
  assign o_valid    = valid_q;
  assign o_data_out = state_reg;
  assign o_sb_data  = state_reg;

`ifdef AES_CTRL_DBG_EN
  assign o_dbg_state = state;
  assign o_dbg_round = round_cnt;
`else
  // Debug taps compiled out.
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: a default instance (AES-128, SB_LATENCY=1) and an
// AES-256 instance with SB_LATENCY=2, each fed by a behavioural s_box pipeline and key store.
module tb_aes_round_ctrl;

  logic         clk;
  logic         rst;
  logic         vld   [2];
  logic         ordy  [2];
  logic [127:0] din   [2];
  logic         ovld  [2];
  logic         rdy   [2];
  logic [127:0] dout  [2];
  logic [3:0]   rkidx [2];
  logic [127:0] rkey  [2];
  logic [127:0] sbo   [2];
  logic [127:0] sbi   [2];
  logic [127:0] sb_mid;
`ifdef AES_CTRL_DBG_EN
  logic [1:0]   dbg_state [2];
  logic [3:0]   dbg_round [2];
`endif

  logic [127:0] rk_store [2][16];
  logic [127:0] rk_tmp [16];
  logic [7:0]   sbox_tab [256];
  int           checks;
  int           failures;
  int           nr_of  [2];
  int           lat_of [2];

  aes_round_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vld[0]), .o_ready(ordy[0]), .i_data_in(din[0]),
    .o_valid(ovld[0]), .i_ready(rdy[0]), .o_data_out(dout[0]), .o_rk_idx(rkidx[0]),
    .i_round_key(rkey[0]), .o_sb_data(sbo[0]), .i_sb_data(sbi[0])
`ifdef AES_CTRL_DBG_EN
    , .o_dbg_state(dbg_state[0]), .o_dbg_round(dbg_round[0])
`endif
  );

  aes_round_ctrl #(.NUM_ROUNDS(14), .SB_LATENCY(2)) dut14 (
    .i_clk(clk), .i_rst(rst), .i_valid(vld[1]), .o_ready(ordy[1]), .i_data_in(din[1]),
    .o_valid(ovld[1]), .i_ready(rdy[1]), .o_data_out(dout[1]), .o_rk_idx(rkidx[1]),
    .i_round_key(rkey[1]), .o_sb_data(sbo[1]), .i_sb_data(sbi[1])
`ifdef AES_CTRL_DBG_EN
    , .o_dbg_state(dbg_state[1]), .o_dbg_round(dbg_round[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rkey[0] = rk_store[0][rkidx[0]];
  assign rkey[1] = rk_store[1][rkidx[1]];

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int i = 0; i < 256; i++) begin
      inv = (i == 0) ? 8'h00 : 8'h01;
      if (i != 0) for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(i));
      sbox_tab[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] x);
    logic [127:0] r;
    for (int n = 0; n < 16; n++) r[127 - 8*n -: 8] = sbox_tab[x[127 - 8*n -: 8]];
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // Key schedule: key bytes left-aligned in 256 bits, nk = 4/6/8 words.
  task automatic expand_key(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] temp;
    logic [7:0]  rcon;
    int          total;
    total = 4 * (nk + 7);
    rcon = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < total; i++) begin
      temp = w[i-1];
      if (i % nk == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        temp = sub_word(temp);
      end
      w[i] = w[i-nk] ^ temp;
    end
    for (int r = 0; r < 16; r++)
      rk_tmp[r] = (r <= nk + 6) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Whole-cipher model on a byte array, using rk_tmp from the last expand_key.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] out;
    for (int n = 0; n < 16; n++) s[n] = pt[127 - 8*n -: 8] ^ rk_tmp[0][127 - 8*n -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int n = 0; n < 16; n++) s[n] = sbox_tab[s[n]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[4*c + row] = s[4*((c + row) % 4) + row];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < nr) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk_tmp[r][127 - 8*n -: 8];
    end
    for (int n = 0; n < 16; n++) out[127 - 8*n -: 8] = s[n];
    return out;
  endfunction

  // s_box pipelines: one register stage for dut, two for dut14.
  always @(posedge clk) begin
    sbi[0] <= sub_bytes(sbo[0]);
    sb_mid <= sub_bytes(sbo[1]);
    sbi[1] <= sb_mid;
  end

  // ---------------- checking helpers ----------------
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_block(input int sel, input logic [127:0] pt, input logic [255:0] key,
                             input int nk);
    int n;
    expand_key(key, nk);
    for (int r = 0; r < 16; r++) rk_store[sel][r] = rk_tmp[r];
    @(negedge clk);
    din[sel] = pt;
    vld[sel] = 1'b1;
    n = 0;
    while (!ordy[sel] && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_before_accept", {127'b0, ordy[sel]}, 128'd1);
    @(posedge clk);
    #1;
    vld[sel] = 1'b0;
  endtask

  task automatic wait_valid(input int sel, inout int cycles);
    while (!ovld[sel] && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic applyStimulus(input int sel, input logic [127:0] pt, input logic [255:0] key,
                               input int nk, input logic [127:0] exp);
    int cycles;
    start_block(sel, pt, key, nk);
    cycles = 0;
    wait_valid(sel, cycles);
    checkOutput("latency", 128'(cycles), 128'(nr_of[sel] * (lat_of[sel] + 1)));
    checkOutput("ciphertext", dout[sel], exp);
  endtask

  task automatic release_out(input int sel);
    @(negedge clk);
    rdy[sel] = 1'b1;
    @(posedge clk);
    #1;
    rdy[sel] = 1'b0;
    checkOutput("valid_after_release", {127'b0, ovld[sel]}, 128'd0);
    checkOutput("ready_after_release", {127'b0, ordy[sel]}, 128'd1);
  endtask

  typedef struct {
    int           sel;
    int           nk;
    logic [127:0] pt;
    logic [255:0] key;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] PT_FIPS  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_C1   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C3   =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3    = 128'h8ea2b7ca516745bfeafc49904b496089;

  vec_t vecs [8];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] pt2;
    logic [127:0] exp2;
    int           total;
    checks = 0;
    failures = 0;
    nr_of[0] = 10; lat_of[0] = 1;
    nr_of[1] = 14; lat_of[1] = 2;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      vld[s] = 1'b0; rdy[s] = 1'b0; din[s] = '0;
      for (int r = 0; r < 16; r++) rk_store[s][r] = '0;
    end
    build_sbox();

    // Reset state
    #3;
    checkOutput("reset_ready_forced", {127'b0, ordy[0]}, 128'd0);
    checkOutput("reset_valid", {127'b0, ovld[0]}, 128'd0);
    checkOutput("reset_rk_idx", 128'(rkidx[0]), 128'd0);
    checkOutput("reset_data", dout[0], 128'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_reset", {127'b0, ordy[0]}, 128'd1);
    checkOutput("ready14_after_reset", {127'b0, ordy[1]}, 128'd1);

    // Vector table: known-answer entries plus random blocks scored by the model
    vecs[0] = '{sel: 0, nk: 4, pt: PT_FIPS, key: KEY_C1, exp: CT_C1};
    vecs[5] = '{sel: 1, nk: 8, pt: PT_FIPS, key: KEY_C3, exp: CT_C3};
    for (int i = 1; i < 8; i++) begin
      if (i == 5) continue;
      vecs[i].sel = (i < 5) ? 0 : 1;
      vecs[i].nk  = (i < 5) ? 4 : 8;
      vecs[i].pt  = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].key = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
      if (vecs[i].nk == 4) vecs[i].key[127:0] = '0;
      expand_key(vecs[i].key, vecs[i].nk);
      vecs[i].exp = aes_ref(vecs[i].pt, vecs[i].nk + 6);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].pt, vecs[i].key, vecs[i].nk, vecs[i].exp);
      release_out(vecs[i].sel);
    end

    // Back-pressure: hold DONE for 7 cycles
    applyStimulus(0, PT_FIPS, KEY_C1, 4, CT_C1);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_valid_hold", {127'b0, ovld[0]}, 128'd1);
      checkOutput("bp_data_hold", dout[0], CT_C1);
      checkOutput("bp_ready_low", {127'b0, ordy[0]}, 128'd0);
`ifdef AES_CTRL_DBG_EN
      checkOutput("dbg_state_done", 128'(dbg_state[0]), 128'd3);
      checkOutput("dbg_round_done", 128'(dbg_round[0]), 128'd10);
`endif
    end
    release_out(0);
`ifdef AES_CTRL_DBG_EN
    checkOutput("dbg_state_idle", 128'(dbg_state[0]), 128'd0);
`endif

    // Busy ignore: second block pulsed at round 5
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    start_block(0, PT_FIPS, KEY_C1, 4);
    total = 0;
    while (rkidx[0] != 4'd5 && total < 100) begin
      @(posedge clk);
      #1;
      total++;
    end
    din[0] = pt2;
    vld[0] = 1'b1;
    checkOutput("busy_ready_low", {127'b0, ordy[0]}, 128'd0);
    @(posedge clk);
    #1;
    total++;
    vld[0] = 1'b0;
    wait_valid(0, total);
    checkOutput("busy_latency", 128'(total), 128'd20);
    checkOutput("busy_ciphertext", dout[0], CT_C1);
    release_out(0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("busy_not_queued", {127'b0, ovld[0]}, 128'd0);
    expand_key(KEY_C1, 4);
    exp2 = aes_ref(pt2, 10);
    applyStimulus(0, pt2, KEY_C1, 4, exp2);
    release_out(0);

    // Reset during MIX of round 4
    start_block(0, PT_FIPS, KEY_C1, 4);
    total = 0;
    while (rkidx[0] != 4'd4 && total < 100) begin
      @(posedge clk);
      #1;
      total++;
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_valid", {127'b0, ovld[0]}, 128'd0);
    checkOutput("abort_rk_idx", 128'(rkidx[0]), 128'd0);
    checkOutput("abort_ready", {127'b0, ordy[0]}, 128'd0);
    checkOutput("abort_data", dout[0], 128'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_ready_release", {127'b0, ordy[0]}, 128'd1);
    applyStimulus(0, PT_FIPS, KEY_C1, 4, CT_C1);
    release_out(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
